// File: rtl/core_pkg.sv
// Shared front-end types and default widths.
// Imported by the PC sequencer and its return-address stack.
package core_pkg;
  localparam int XLEN_DEF = 32;
  localparam int STEP_DEF = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } pc_state_e;
endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack: circular buffer with saturating count.
// When full, a push overwrites the oldest entry.
module ret_addr_stack
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_top;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;
  logic             w_repl;
  logic [AW-1:0]    w_wr_idx;

  assign w_pop    = pop && (r_cnt != '0);
  assign w_repl   = push && w_pop;
  assign w_wr_idx = w_repl ? r_top : r_top + AW'(1);
  assign top      = r_mem[r_top];
  assign empty    = (r_cnt == '0);

  // Track top index and occupancy; pop-then-push nets out to a replace.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_top <= '0;
      r_cnt <= '0;
    end else if (w_repl) begin
      r_top <= r_top;
    end else if (push) begin
      r_top <= r_top + AW'(1);
      if (r_cnt != CW'(DEPTH))
        r_cnt <= r_cnt + CW'(1);
    end else if (w_pop) begin
      r_top <= r_top - AW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Entry storage; contents beyond the count are don't-care.
  always_ff @(posedge clk) begin
    if (push)
      r_mem[w_wr_idx] <= push_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC unit: boot/run/fault FSM, target adder, redirect mux.
// Priority each cycle: trap, then resolved branch, then sequential.
module pc_sequencer
  import core_pkg::*;
#(
  parameter int             XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter int             STEP         = STEP_DEF,
  parameter int             RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            br_valid,
  input  logic            br_isjalr,
  input  logic [XLEN-1:0] br_base_pc,
  input  logic [XLEN-1:0] br_offset,
  input  logic [XLEN-1:0] br_jalr_reg,
  input  logic            br_is_call,
  input  logic            br_is_ret,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic            misalign_valid,
  output logic [XLEN-1:0] misalign_pc,
  output logic            ras_empty
);
  pc_state_e       r_state;
  pc_state_e       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_mis;
  logic            w_mis_nxt;
  logic [XLEN-1:0] r_mis_pc;
  logic [XLEN-1:0] w_mis_pc_nxt;

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_calc;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_ras_top;
  logic [XLEN-1:0] w_push_data;
  logic            w_ras_empty;
  logic            w_ras_hit;
  logic            w_misal;
  logic            w_push;
  logic            w_pop;

  assign w_base      = br_isjalr ? br_jalr_reg : br_base_pc;
  assign w_sum       = w_base + br_offset;
  assign w_calc      = {w_sum[XLEN-1:1], w_sum[0] & ~br_isjalr};
  assign w_ras_hit   = br_is_ret && !w_ras_empty;
  assign w_target    = w_ras_hit ? w_ras_top : w_calc;
  assign w_misal     = |w_target[1:0];
  assign w_push_data = br_base_pc + XLEN'(STEP);

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_push_data),
    .top       (w_ras_top),
    .empty     (w_ras_empty)
  );

  // State, PC and fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= BOOT;
      r_pc     <= RESET_VECTOR;
      r_mis    <= 1'b0;
      r_mis_pc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_mis    <= w_mis_nxt;
      r_mis_pc <= w_mis_pc_nxt;
    end
  end

  // Next state, next PC and RAS control in priority order.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_mis_nxt    = 1'b0;
    w_mis_pc_nxt = r_mis_pc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    if (trap_valid) begin
      w_pc_nxt    = trap_vector;
      w_state_nxt = RUN;
    end else begin
      unique case (r_state)
        BOOT: w_state_nxt = RUN;
        RUN: begin
          if (br_valid) begin
            if (w_misal) begin
              w_state_nxt  = FAULT;
              w_mis_nxt    = 1'b1;
              w_mis_pc_nxt = w_target;
            end else begin
              w_pc_nxt = w_target;
              w_push   = br_is_call;
              w_pop    = br_is_ret;
            end
          end else if (fetch_ready) begin
            w_pc_nxt = r_pc + XLEN'(STEP);
          end
        end
        FAULT: w_state_nxt = FAULT;
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  assign fetch_valid    = (r_state == RUN);
  assign fetch_pc       = r_pc;
  assign misalign_valid = r_mis;
  assign misalign_pc    = r_mis_pc;
  assign ras_empty      = w_ras_empty;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic.
// Expectations come from a queue-based reference model.
module tb_pc_sequencer;
  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        br_valid;
  logic        br_isjalr;
  logic [31:0] br_base_pc;
  logic [31:0] br_offset;
  logic [31:0] br_jalr_reg;
  logic        br_is_call;
  logic        br_is_ret;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        misalign_valid;
  logic [31:0] misalign_pc;
  logic        ras_empty;

  pc_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .br_valid       (br_valid),
    .br_isjalr      (br_isjalr),
    .br_base_pc     (br_base_pc),
    .br_offset      (br_offset),
    .br_jalr_reg    (br_jalr_reg),
    .br_is_call     (br_is_call),
    .br_is_ret      (br_is_ret),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .misalign_valid (misalign_valid),
    .misalign_pc    (misalign_pc),
    .ras_empty      (ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // model: mode 0 = booting, 1 = running, 2 = faulted
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_mv;
  logic [31:0] m_mpc;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_tick();
    logic [31:0] t;
    logic        hit;
    m_mv = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_pc   = 32'h8000_0000;
      m_mpc  = '0;
      m_ras.delete();
    end else if (trap_valid) begin
      m_pc   = trap_vector;
      m_mode = 1;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (br_valid) begin
        t = (br_isjalr ? br_jalr_reg : br_base_pc) + br_offset;
        if (br_isjalr) t[0] = 1'b0;
        hit = br_is_ret && (m_ras.size() > 0);
        if (hit) t = m_ras[$];
        if (t[1:0] != 2'b00) begin
          m_mode = 2;
          m_mv   = 1'b1;
          m_mpc  = t;
        end else begin
          m_pc = t;
          if (hit) void'(m_ras.pop_back());
          if (br_is_call) begin
            m_ras.push_back(br_base_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
          end
        end
      end else if (fetch_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk("pc", fetch_pc, m_pc);
    chk("valid", 32'(fetch_valid), 32'(m_mode == 1));
    chk("mis_v", 32'(misalign_valid), 32'(m_mv));
    chk("mis_pc", misalign_pc, m_mpc);
    chk("ras_e", 32'(ras_empty), 32'(m_ras.size() == 0));
  endtask

  task automatic clr_br();
    br_valid    = 1'b0;
    br_isjalr   = 1'b0;
    br_base_pc  = '0;
    br_offset   = '0;
    br_jalr_reg = '0;
    br_is_call  = 1'b0;
    br_is_ret   = 1'b0;
  endtask

  task automatic do_br(input logic jr, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] reg_v,
                       input logic call, input logic ret);
    br_valid    = 1'b1;
    br_isjalr   = jr;
    br_base_pc  = base;
    br_offset   = off;
    br_jalr_reg = reg_v;
    br_is_call  = call;
    br_is_ret   = ret;
    step();
    clr_br();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    m_mode = 0;
    m_pc = 32'h8000_0000;
    m_mv = 1'b0;
    m_mpc = '0;
    clr_br();
    trap_valid  = 1'b0;
    trap_vector = '0;
    fetch_ready = 1'b1;
    rst = 1'b1;
    #2;
    step();
    step();
    chk("rst_pc", fetch_pc, 32'h8000_0000);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_ras", 32'(ras_empty), 32'd1);
    rst = 1'b0;
    step();
    chk("boot_valid", 32'(fetch_valid), 32'd1);
    step();
    chk("seq_pc", fetch_pc, 32'h8000_0004);
    fetch_ready = 1'b0;
    repeat (3) step();
    chk("stall_pc", fetch_pc, 32'h8000_0004);
    fetch_ready = 1'b1;
    step();
    chk("resume_pc", fetch_pc, 32'h8000_0008);
    step();
    do_br(1'b0, 32'h8000_0010, 32'hFFFF_FFF8, '0, 1'b0, 1'b0);
    chk("br_pc", fetch_pc, 32'h8000_0008);
    trap_valid  = 1'b1;
    trap_vector = 32'h8000_0100;
    do_br(1'b0, 32'h8000_0010, 32'hFFFF_FFF8, '0, 1'b0, 1'b0);
    trap_valid  = 1'b0;
    chk("trap_pc", fetch_pc, 32'h8000_0100);
    do_br(1'b1, '0, '0, 32'h8000_1003, 1'b0, 1'b0);
    chk("mis_pulse", 32'(misalign_valid), 32'd1);
    chk("mis_addr", misalign_pc, 32'h8000_1002);
    chk("mis_valid", 32'(fetch_valid), 32'd0);
    step();
    chk("mis_drop", 32'(misalign_valid), 32'd0);
    do_br(1'b0, 32'h8000_0040, 32'h10, '0, 1'b0, 1'b0);
    chk("fault_hold", 32'(fetch_valid), 32'd0);
    trap_valid  = 1'b1;
    trap_vector = 32'h8000_0100;
    step();
    trap_valid  = 1'b0;
    chk("fault_exit", fetch_pc, 32'h8000_0100);
    do_br(1'b0, 32'h8000_0020, 32'h40, '0, 1'b1, 1'b0);
    do_br(1'b1, '0, '0, 32'h1234, 1'b0, 1'b1);
    chk("ret_pc", fetch_pc, 32'h8000_0024);
    chk("ret_empty", 32'(ras_empty), 32'd1);
    for (int i = 0; i < 5; i++)
      do_br(1'b0, 32'h8000_0000 + 32'(i * 16), 32'h100, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_br(1'b1, '0, '0, 32'h2000, 1'b0, 1'b1);
      chk("ovf_ret", fetch_pc, 32'h8000_0044 - 32'(i * 16));
    end
    do_br(1'b1, '0, '0, 32'h2000, 1'b0, 1'b1);
    chk("ovf_last", fetch_pc, 32'h2000);

    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      trap_valid  = ($urandom_range(0, 14) == 0);
      trap_vector = $urandom & 32'hFFFF_FFFC;
      fetch_ready = ($urandom_range(0, 3) != 0);
      br_valid    = ($urandom_range(0, 3) == 0);
      br_isjalr   = $urandom_range(0, 1) == 1;
      br_base_pc  = $urandom & 32'hFFFF_FFFC;
      br_offset   = $urandom;
      if ($urandom_range(0, 3) != 0) br_offset[1:0] = 2'b00;
      br_jalr_reg = $urandom;
      if ($urandom_range(0, 3) != 0) br_jalr_reg[1:0] = 2'b00;
      br_is_call  = ($urandom_range(0, 2) == 0);
      br_is_ret   = ($urandom_range(0, 2) == 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
